// File: rtl/vector_loader_pkg.sv
// Shared vector-machine definitions.
//   VM_WORD_SIZE : default element / stream width
//   VM_ADDR_W    : default per-bank memory address width
//   vl_state_e   : loader FSM state encoding
package vector_loader_pkg;

  localparam int unsigned VM_WORD_SIZE = 24;
  localparam int unsigned VM_ADDR_W    = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    FIRE   = 2'd3
  } vl_state_e;

endpackage

// File: rtl/vl_wr_port.sv
// Registered write-port driver for one memory bank.
//   clk, rst        : clock, asynchronous active-low reset
//   en_in           : write this cycle's addr_in/data_in on the next cycle
//   addr_in/data_in : address and data to register
//   wr_en           : one-cycle write strobe
//   wr_addr/wr_data : registered bus, holds its last value when wr_en is low
module vl_wr_port
  import vector_loader_pkg::*;
#(
  parameter int unsigned word_size = VM_WORD_SIZE,
  parameter int unsigned ADDR_W    = VM_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_in,
  input  logic [ADDR_W-1:0]    addr_in,
  input  logic [word_size-1:0] data_in,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [word_size-1:0] wr_data
);

  logic                 en_q, en_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [word_size-1:0] data_q, data_d;

  always_comb begin
    en_d   = en_in;
    addr_d = en_in ? addr_in : addr_q;
    data_d = en_in ? data_in : data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign wr_en   = en_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;

endmodule

// File: rtl/vector_loader.sv
// Operand-memory writer: streams 2*VEC_LEN words into bank 1 then bank 2,
// then pulses start to the control unit.
//   clk, rst            : clock, asynchronous active-low reset
//   load_req            : begin a load (honoured only in IDLE)
//   in_data/in_valid    : stream input, in_ready accepts a beat
//   wr_en1/addr1/data1  : bank-1 write port (registered)
//   wr_en2/addr2/data2  : bank-2 write port (registered)
//   busy                : state is not IDLE
//   start               : one-cycle pulse, both vectors written
//   err                 : one-cycle pulse, load_req ignored while busy
module vector_loader
  import vector_loader_pkg::*;
#(
  parameter int unsigned word_size = VM_WORD_SIZE,
  parameter int unsigned ADDR_W    = VM_ADDR_W,
  parameter int unsigned VEC_LEN   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_req,
  input  logic [word_size-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en1,
  output logic [ADDR_W-1:0]    wr_addr1,
  output logic [word_size-1:0] wr_data1,
  output logic                 wr_en2,
  output logic [ADDR_W-1:0]    wr_addr2,
  output logic [word_size-1:0] wr_data2,
  output logic                 busy,
  output logic                 start,
  output logic                 err
);

  // One extra counter bit so VEC_LEN == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(VEC_LEN - 1);

  vl_state_e       state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            start_q, start_d;
  logic            err_q, err_d;
  logic            beat;

  assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign beat     = in_valid && in_ready;
  assign busy     = (state_q != IDLE);
  assign start    = start_q;
  assign err      = err_q;

  // FIRE lasts two cycles: the first carries the final bank-2 write, the
  // second raises start, so busy and start drop together on return to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    err_d   = load_req && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
      end
      LOAD_A, LOAD_B: begin
        if (beat) begin
          if (cnt_q == LAST) begin
            state_d = (state_q == LOAD_A) ? LOAD_B : FIRE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + (ADDR_W+1)'(1);
          end
        end
      end
      FIRE: begin
        if (!start_q) start_d = 1'b1;
        else          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  vl_wr_port #(.word_size(word_size), .ADDR_W(ADDR_W)) u_port1 (
    .clk     (clk),
    .rst     (rst),
    .en_in   (beat && (state_q == LOAD_A)),
    .addr_in (cnt_q[ADDR_W-1:0]),
    .data_in (in_data),
    .wr_en   (wr_en1),
    .wr_addr (wr_addr1),
    .wr_data (wr_data1)
  );

  vl_wr_port #(.word_size(word_size), .ADDR_W(ADDR_W)) u_port2 (
    .clk     (clk),
    .rst     (rst),
    .en_in   (beat && (state_q == LOAD_B)),
    .addr_in (cnt_q[ADDR_W-1:0]),
    .data_in (in_data),
    .wr_en   (wr_en2),
    .wr_addr (wr_addr2),
    .wr_data (wr_data2)
  );

endmodule

// File: doc/vector_loader.md
Name: vector_loader

Overview:
- Writer side of the vector machine's operand memory.
- Accepts a valid/ready stream of 24-bit words and writes the first VEC_LEN words into bank 1 (operand data_1) and the next VEC_LEN words into bank 2 (operand data_2), both at addresses 0..VEC_LEN-1.
- After the final write it pulses start to the control unit, so a full load-then-compute run needs no external sequencing.
- Sits between the host/testbench data source and the memory unit's write ports.

Parameters:
- word_size, 24, width of each vector element and of the stream data.
- ADDR_W, 9, memory address width for each bank.
- VEC_LEN, 256, elements per vector; legal range 1..2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- load_req  input  1  one-cycle request to begin a load; honoured only in IDLE.
- in_data  input  word_size  stream element.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a beat this cycle.
- wr_en1  output  1  bank-1 write strobe.
- wr_addr1  output  ADDR_W  bank-1 write address.
- wr_data1  output  word_size  bank-1 write data.
- wr_en2  output  1  bank-2 write strobe.
- wr_addr2  output  ADDR_W  bank-2 write address.
- wr_data2  output  word_size  bank-2 write data.
- busy  output  1  high whenever the state is not IDLE.
- start  output  1  one-cycle pulse to the control unit: both vectors are in memory.
- err  output  1  one-cycle pulse: load_req arrived while busy and was ignored.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, element counter = 0.
  - Every output is 0, including the wr_addr* and wr_data* buses.
  - Memory contents after a mid-load reset are unspecified; the loader never clears memory.
- States: IDLE, LOAD_A, LOAD_B, FIRE.
- IDLE:
  - in_ready = 0.
  - load_req = 1 → LOAD_A with counter = 0.
- Handshake:
  - A beat is accepted when in_valid & in_ready are both high at a rising edge.
  - in_ready = 1 throughout LOAD_A and LOAD_B, and is driven combinationally from state.
  - in_valid may be held low for any number of cycles; no beat is lost or duplicated.
- LOAD_A:
  - A beat accepted at edge k makes wr_en1 = 1, wr_addr1 = counter and wr_data1 = in_data valid during cycle k+1 (registered writes). The counter then increments.
  - On the beat with counter == VEC_LEN-1: go to LOAD_B and reset counter to 0.
  - in_ready stays high across the A→B transition, so B element 0 can be accepted in the very next cycle (no bubble).
- LOAD_B:
  - Identical to LOAD_A, but targets the wr_*2 ports.
  - On the beat with counter == VEC_LEN-1: go to FIRE.
- FIRE:
  - Entered in the same cycle the final wr_en2 pulse is driven.
  - in_ready = 0.
  - start = 1 for exactly one cycle, the cycle after the final wr_en2, so the write has completed before the control unit reads.
  - Then return to IDLE.
- Write-strobe rules:
  - wr_en1 and wr_en2 are never high in the same cycle.
  - At most one write strobe per accepted beat.
  - wr_addr* and wr_data* hold their last values when the strobe is low.
- Counter:
  - Width ADDR_W+1, so VEC_LEN == 2**ADDR_W never wraps before the compare.
  - The stored address is counter[ADDR_W-1:0].
- load_req while busy:
  - The request is ignored, with no state change.
  - err pulses one cycle later, for one cycle.
  - A simultaneous accepted beat is processed normally.
- VEC_LEN == 1: exactly one beat in LOAD_A, one in LOAD_B, then FIRE.
- Beats offered in IDLE or FIRE are not accepted (in_ready = 0); the source holds them.

Decomposition:
- Shared vector-machine package holds:
  - word_size and ADDR_W defaults, shared with the control unit, calculation block and memory unit.
  - State encodings for IDLE, LOAD_A, LOAD_B, FIRE.
- One natural sub-module: vl_wr_port, the registered write-port driver (en/addr/data register with hold), instantiated once per bank.
- FSM and counter stay in vector_loader.

Test Plan:
- VEC_LEN=4; load_req, then 8 consecutive beats 1..8 → wr_en1 at addr 0..3 with data 1..4, wr_en2 at addr 0..3 with data 5..8, one write per cycle; start high one cycle after the last wr_en2; busy falls with start.
- Same run with in_valid low every other cycle → identical addresses and data, no duplicates; the A→B boundary stays gap-free when in_valid is held high.
- load_req pulsed during LOAD_B at beat 2 → err one-cycle pulse; load continues; start fires after 8 total beats.
- rst driven low mid-LOAD_A after 2 beats, asynchronously between edges → all outputs 0 immediately; next load_req restarts at wr_addr1 = 0.
- VEC_LEN=1; beats 0xABCDEF and 0x123456 → wr_en1 addr 0 = 0xABCDEF, wr_en2 addr 0 = 0x123456, start the cycle after the wr_en2 pulse.
- in_valid high in IDLE with no load_req for 10 cycles → in_ready stays 0 and no wr_en pulses.
